multicycle_controller: RTL
==========================

// Module: multicycle_controller
// PURPOSE
//  Multi-cycle control FSM for the RV32I datapath. It replaces the constant pc_write/ir_write
//  ties and sequences each instruction through FETCH, DECODE, EXECUTE, MEM and WB.
//  It handshakes with instruction and data memory, halts on illegal, system or timeout
//  events, and counts retired instructions.
// PARAMETERS
//  MEM_TIMEOUT  15  max consecutive not-ready wait cycles in FETCH/MEM before fault; 0 = disabled
//  CNT_WIDTH    32  width of instret counter
// PORTS
//  clk          in   1   single clock, rising edge
//  reset        in   1   synchronous, active-low; state cleared on the clk edge where reset==0
//  run          in   1   1 = start next instruction; sampled only in FETCH
//  opcode       in   7   instruction[6:0] from instruction register
//  branch_taken in   1   branch condition from ALU compare, valid in EXECUTE
//  imem_ready   in   1   instruction memory data valid this cycle
//  dmem_ready   in   1   data memory read data valid / write accepted this cycle
//  imem_req     out  1   fetch request
//  ir_write     out  1   load instruction register
//  pc_write     out  1   update PC (retire strobe)
//  pc_src       out  1   0 = pc+4, 1 = ALU target; meaningful only when pc_write=1
//  reg_write    out  1   register file write enable
//  mem_read     out  1   data memory read request
//  mem_write    out  1   data memory write request
//  state        out  3   FETCH=0 DECODE=1 EXECUTE=2 MEM=3 WB=4 HALT=5
//  halted       out  1   1 while in HALT
//  fault_code   out  2   0 none, 1 illegal opcode, 2 SYSTEM (ecall/ebreak), 3 mem timeout
//  instret      out  CNT_WIDTH  retired-instruction count
// BEHAVIOUR
//  Reset (reset==0 at edge), from any state including mid-MEM:
//   - next state=FETCH; halted=0; fault_code=0; instret=0; wait counter=0.
//   - All strobes are forced 0 in any cycle where reset==0.
//  Strobes are combinational from (state, opcode, ready, branch_taken).
//  FETCH:
//   - imem_req=run. Stay while run=0 or imem_ready=0.
//   - ir_write=1 in the cycle run&imem_ready, then go to DECODE.
//  DECODE: one cycle; no strobes; opcode classified.
//   - Legal: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111, 0001111.
//   - 1110011: next state HALT, fault_code=2.
//   - Any other opcode: next state HALT, fault_code=1.
//  EXECUTE: one cycle.
//   - Branch: pc_write=1, pc_src=branch_taken -> FETCH.
//   - FENCE: pc_write=1, pc_src=0 -> FETCH.
//   - Load/store -> MEM.
//   - All others -> WB.
//  MEM:
//   - mem_read (load) or mem_write (store) held high until the dmem_ready cycle, inclusive.
//   - Load, ready: -> WB.
//   - Store, ready: pc_write=1, pc_src=0 in that same cycle -> FETCH.
//  WB: one cycle; reg_write=1; pc_write=1 -> FETCH.
//   - pc_src=1 for JAL/JALR, 0 otherwise.
//  HALT: all strobes 0; holds until reset; fault_code held.
//  Timeout:
//   - Wait counter clears on entry to FETCH/MEM.
//   - It increments on each cycle with (FETCH&run&!imem_ready) or (MEM&!dmem_ready).
//   - A not-ready cycle with counter==MEM_TIMEOUT-1 -> HALT, fault_code=3.
//   - Ready in that same cycle wins; no fault.
//  instret: +1 on every edge where pc_write=1; wraps 2^CNT_WIDTH-1 -> 0.
//  Latency with ready tied 1:
//   - ALU/LUI/AUIPC/JAL/JALR 4 cycles; load 5; store 4; branch/FENCE 3.
//   - Each not-ready cycle adds one.
//  At most one of mem_read/mem_write/reg_write/ir_write high per cycle.
// TESTING
//  T1: run=1, readies=1, ADDI (0010011) -> state 0,1,2,4,0.
//      reg_write and pc_write high only in WB with pc_src=0; instret 0->1.
//  T2: LW, dmem_ready low 3 cycles then high -> mem_read high 4 cycles.
//      Then WB with reg_write; instruction total 8 cycles.
//  T3: BEQ with branch_taken=1, then =0 -> EXECUTE pc_write=1 with pc_src=1, then 0.
//      No reg_write; 3 cycles each.
//  T4: MEM_TIMEOUT=4, SW with dmem_ready held 0 -> 4 MEM cycles with mem_write=1.
//      Then HALT: fault_code=3, halted=1, strobes 0. Holds until reset.
//  T5: opcode 7'h7F -> HALT with fault_code=1; opcode 7'h73 -> fault_code=2.
//      reset=0 during MEM of a store -> next cycle FETCH, mem_write=0, instret=0.
//  T6: run=0 for 5 cycles -> stays in FETCH, imem_req=0.
//      CNT_WIDTH=4 with 16 retires -> instret wraps 15->0.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Handshake and control bundle between the multicycle
// controller and the RV32I datapath / memories.
interface multicycle_controller_if #(
  parameter int CNT_WIDTH = 32
);
  logic                 run;
  logic [6:0]           opcode;
  logic                 branch_taken;
  logic                 imem_ready;
  logic                 dmem_ready;
  logic                 imem_req;
  logic                 ir_write;
  logic                 pc_write;
  logic                 pc_src;
  logic                 reg_write;
  logic                 mem_read;
  logic                 mem_write;
  logic [2:0]           state;
  logic                 halted;
  logic [1:0]           fault_code;
  logic [CNT_WIDTH-1:0] instret;

  modport master (
    input  run, opcode, branch_taken,
    input  imem_ready, dmem_ready,
    output imem_req, ir_write, pc_write,
    output pc_src, reg_write,
    output mem_read, mem_write,
    output state, halted, fault_code,
    output instret
  );

  modport slave (
    output run, opcode, branch_taken,
    output imem_ready, dmem_ready,
    input  imem_req, ir_write, pc_write,
    input  pc_src, reg_write,
    input  mem_read, mem_write,
    input  state, halted, fault_code,
    input  instret
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: sequences FETCH..WB,
// handshakes with memories, halts on faults, counts retires.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_WIDTH   = 32
) (
  input logic clk,
  input logic reset,
  multicycle_controller_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  localparam logic [15:0] TO_LAST =
    16'(MEM_TIMEOUT - 1);

  state_t               state_q;
  state_t               state_n;
  logic [1:0]           fault_q;
  logic [1:0]           fault_n;
  logic [15:0]          wcnt_q;
  logic [CNT_WIDTH-1:0] instret_q;

  logic imem_req_r;
  logic ir_write_r;
  logic pc_write_r;
  logic pc_src_r;
  logic reg_write_r;
  logic mem_read_r;
  logic mem_write_r;

  logic [6:0] op;
  logic is_r, is_i, is_ld, is_st, is_br;
  logic is_jal, is_jalr, is_lui, is_auipc;
  logic is_fence, is_sys, is_legal;
  logic wait_cyc;
  logic to_hit;

  assign op       = bus.opcode;
  assign is_r     = op == 7'b0110011;
  assign is_i     = op == 7'b0010011;
  assign is_ld    = op == 7'b0000011;
  assign is_st    = op == 7'b0100011;
  assign is_br    = op == 7'b1100011;
  assign is_jal   = op == 7'b1101111;
  assign is_jalr  = op == 7'b1100111;
  assign is_lui   = op == 7'b0110111;
  assign is_auipc = op == 7'b0010111;
  assign is_fence = op == 7'b0001111;
  assign is_sys   = op == 7'b1110011;
  assign is_legal = is_r | is_i | is_ld
                  | is_st | is_br | is_jal
                  | is_jalr | is_lui
                  | is_auipc | is_fence;

  assign wait_cyc =
    (state_q == S_FETCH && bus.run &&
     !bus.imem_ready) ||
    (state_q == S_MEM && !bus.dmem_ready);

  assign to_hit = (MEM_TIMEOUT != 0) &&
                  (wcnt_q == TO_LAST);

  // Next-state, fault capture and raw strobes.
  always_comb begin
    state_n     = state_q;
    fault_n     = fault_q;
    imem_req_r  = 1'b0;
    ir_write_r  = 1'b0;
    pc_write_r  = 1'b0;
    pc_src_r    = 1'b0;
    reg_write_r = 1'b0;
    mem_read_r  = 1'b0;
    mem_write_r = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        imem_req_r = bus.run;
        if (bus.run && bus.imem_ready) begin
          ir_write_r = 1'b1;
          state_n    = S_DECODE;
        end else if (wait_cyc && to_hit) begin
          state_n = S_HALT;
          fault_n = 2'd3;
        end
      end
      S_DECODE: begin
        unique case (1'b1)
          is_legal: state_n = S_EXECUTE;
          is_sys: begin
            state_n = S_HALT;
            fault_n = 2'd2;
          end
          default: begin
            state_n = S_HALT;
            fault_n = 2'd1;
          end
        endcase
      end
      S_EXECUTE: begin
        unique case (1'b1)
          is_br: begin
            pc_write_r = 1'b1;
            pc_src_r   = bus.branch_taken;
            state_n    = S_FETCH;
          end
          is_fence: begin
            pc_write_r = 1'b1;
            state_n    = S_FETCH;
          end
          is_ld, is_st: state_n = S_MEM;
          default: state_n = S_WB;
        endcase
      end
      S_MEM: begin
        mem_read_r  = is_ld;
        mem_write_r = is_st;
        if (bus.dmem_ready) begin
          if (is_ld) begin
            state_n = S_WB;
          end else begin
            pc_write_r = is_st;
            state_n    = S_FETCH;
          end
        end else if (to_hit) begin
          state_n = S_HALT;
          fault_n = 2'd3;
        end
      end
      S_WB: begin
        reg_write_r = 1'b1;
        pc_write_r  = 1'b1;
        pc_src_r    = is_jal | is_jalr;
        state_n     = S_FETCH;
      end
      S_HALT: state_n = S_HALT;
      default: state_n = S_FETCH;
    endcase
  end

  // State, fault, wait counter and retire counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      fault_q   <= 2'd0;
      wcnt_q    <= 16'd0;
      instret_q <= '0;
    end else begin
      state_q <= state_n;
      fault_q <= fault_n;
      if (state_n != state_q)
        wcnt_q <= 16'd0;
      else if (wait_cyc)
        wcnt_q <= wcnt_q + 16'd1;
      if (pc_write_r)
        instret_q <= instret_q + 1'b1;
    end
  end

  assign bus.imem_req   = reset & imem_req_r;
  assign bus.ir_write   = reset & ir_write_r;
  assign bus.pc_write   = reset & pc_write_r;
  assign bus.pc_src     = reset & pc_src_r;
  assign bus.reg_write  = reset & reg_write_r;
  assign bus.mem_read   = reset & mem_read_r;
  assign bus.mem_write  = reset & mem_write_r;
  assign bus.state      = state_q;
  assign bus.halted     = state_q == S_HALT;
  assign bus.fault_code = fault_q;
  assign bus.instret    = instret_q;

endmodule
